led_pattern_gen: RTL and testbench

Parametrised LED pattern engine for the iCEBreaker LED bank: drives NUM_LEDS outputs from a shared step prescaler, with four selectable display modes, global PWM brightness and per-pin polarity correction. It replaces hard-wired counter-bit-to-pin assignment as the board-level status/demo driver. It sits directly between the 12 MHz board clock domain and the LED pins.

---
 rtl/led_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   LED pattern engine for a bank of NUM_LEDS pins. A shared prescaler
//   advances one of four display patterns: binary count, bouncing scan,
//   bar fill, or all on. A free-running PWM counter gates the pattern for
//   global brightness. Per-pin polarity is corrected just before the
//   output register.
//
// Ports
//   CLK     in   1         board clock, rising edge
//   RST     in   1         synchronous active-high reset
//   MODE    in   2         0=COUNT 1=SCAN 2=FILL 3=STATIC
//   BRIGHT  in   PWM_W     duty, 0=off, all-ones=always on
//   PAUSE   in   1         freezes prescaler and pattern state
//   LED     out  NUM_LEDS  pin drive, polarity corrected
//   STEP    out  1         one-cycle pulse per pattern advance
module led_pattern_gen #(
  parameter int                  NUM_LEDS        = 7,
  parameter int                  PRESCALE_W      = 22,
  parameter int                  PWM_W           = 4,
  parameter logic [NUM_LEDS-1:0] ACTIVE_LOW_MASK = 7'b0000011
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          MODE,
  input  logic [PWM_W-1:0]    BRIGHT,
  input  logic                PAUSE,
  output logic [NUM_LEDS-1:0] LED,
  output logic                STEP
);

  // A single LED still needs a 1-bit position register.
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  // The fill level counts 0..NUM_LEDS inclusive.
  localparam int K_W   = $clog2(NUM_LEDS + 1);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_STATIC = 2'd3
  } mode_e;

  mode_e                mode_q, mode_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PWM_W-1:0]      pwm_q, pwm_d;
  logic [NUM_LEDS-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  dir_q, dir_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic                  step_q, step_d;

  mode_e                 mode_in;
  logic [NUM_LEDS-1:0]   scan_pat;
  logic [NUM_LEDS-1:0]   fill_pat;
  logic [NUM_LEDS-1:0]   pattern;
  logic                  pwm_on;

  assign mode_in = mode_e'(MODE);

  // Next-state logic. A mode change wipes the pattern state and the
  // prescaler so every mode starts from its first frame with a full step
  // interval. This takes priority over both PAUSE and a pending advance.
  always_comb begin
    mode_d = mode_in;
    pre_d  = pre_q;
    pwm_d  = pwm_q + PWM_W'(1);
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    k_d    = k_q;
    step_d = 1'b0;

    if (mode_in != mode_q) begin
      pre_d = '0;
      cnt_d = '0;
      pos_d = '0;
      dir_d = 1'b0;
      k_d   = '0;
    end else if (!PAUSE) begin
      pre_d = pre_q + PRESCALE_W'(1);
      if (&pre_q) begin
        step_d = 1'b1;
        case (mode_q)
          MODE_COUNT: cnt_d = cnt_q + NUM_LEDS'(1);
          MODE_SCAN: begin
            // Turn around on the end LED itself so each end is lit once
            // per bounce. A single LED never moves.
            if (NUM_LEDS > 1) begin
              if (!dir_q) begin
                if (pos_q == POS_W'(NUM_LEDS - 1)) begin
                  dir_d = 1'b1;
                  pos_d = pos_q - POS_W'(1);
                end else begin
                  pos_d = pos_q + POS_W'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = 1'b0;
                  pos_d = pos_q + POS_W'(1);
                end else begin
                  pos_d = pos_q - POS_W'(1);
                end
              end
            end
          end
          MODE_FILL: k_d = (k_q == K_W'(NUM_LEDS)) ? '0 : k_q + K_W'(1);
          MODE_STATIC: ;
          default: ;
        endcase
      end
    end
  end

  // Pattern and output decode. The pattern is taken from the registered
  // state, so LED trails the state registers by one cycle. All-ones
  // brightness is forced on because pwm < BRIGHT misses one slot per period.
  always_comb begin
    scan_pat = '0;
    fill_pat = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      scan_pat[i] = (pos_q == POS_W'(i));
      fill_pat[i] = (K_W'(i) < k_q);
    end

    pattern = '1;
    case (mode_q)
      MODE_COUNT:  pattern = cnt_q;
      MODE_SCAN:   pattern = scan_pat;
      MODE_FILL:   pattern = fill_pat;
      MODE_STATIC: pattern = '1;
      default:     pattern = '1;
    endcase

    pwm_on = (&BRIGHT) | (pwm_q < BRIGHT);
    led_d  = (pattern & {NUM_LEDS{pwm_on}}) ^ ACTIVE_LOW_MASK;
  end

  // State registers. Reset leaves every pin at its dark level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= MODE_COUNT;
      pre_q  <= '0;
      pwm_q  <= '0;
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      k_q    <= '0;
      led_q  <= ACTIVE_LOW_MASK;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      k_q    <= k_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  assign LED  = led_q;
  assign STEP = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
//   Bench for led_pattern_gen with a 4-LED, 2-bit prescaler, 2-bit PWM
//   configuration. A second instance with mask 4'b0011 covers polarity.
//   Expected LED frames after each STEP are queued by the stimulus and
//   popped by an independent monitor.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] bright;
  logic       pause;
  logic [3:0] led;
  logic       step;
  logic [3:0] led_al;
  logic       step_al;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_q[$];
  bit         mon_on = 1'b0;
  bit         step_prev = 1'b0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS(4), .PRESCALE_W(2), .PWM_W(2), .ACTIVE_LOW_MASK(4'b0000)
  ) u_dut (
    .CLK(clk), .RST(rst), .MODE(mode), .BRIGHT(bright), .PAUSE(pause),
    .LED(led), .STEP(step)
  );

  led_pattern_gen #(
    .NUM_LEDS(4), .PRESCALE_W(2), .PWM_W(2), .ACTIVE_LOW_MASK(4'b0011)
  ) u_dut_al (
    .CLK(clk), .RST(rst), .MODE(mode), .BRIGHT(bright), .PAUSE(pause),
    .LED(led_al), .STEP(step_al)
  );

  task automatic check_output(input string name, input logic [3:0] actual,
                              input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // All stimulus changes and direct samples happen just after a falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // The frame following a STEP cycle is the new pattern; compare it with
  // the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_on && step_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_underflow: got led %b expected no step", led);
      end else begin
        check_output("sb_led", led, exp_q.pop_front());
      end
    end
    step_prev <= step;
  end

  task automatic apply_stimulus(input logic [1:0] m);
    rst    = 1'b1;
    mode   = m;
    pause  = 1'b0;
    bright = 2'd3;
    repeat (3) begin
      tick();
      check_output("reset_led", led, 4'b0000);
      check_output("reset_step", {3'b0, step}, 4'd0);
      check_output("reset_led_al", led_al, 4'b0011);
    end
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d frames left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int ones;

    // Reset, STEP cadence and COUNT sequence.
    for (int i = 1; i <= 17; i++) exp_q.push_back(4'(i));
    apply_stimulus(2'd0);
    mon_on = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_output("step_timing", {3'b0, step}, (k % 4 == 0) ? 4'd1 : 4'd0);
      check_output("step_timing_al", {3'b0, step_al}, (k % 4 == 0) ? 4'd1 : 4'd0);
      if (k == 5) check_output("polarity_0001", led_al, 4'b0010);
    end
    wait_drain(100);
    mon_on = 1'b0;

    // PAUSE freezes COUNT at 0001, then counting resumes.
    pause = 1'b1;
    repeat (10) begin
      tick();
      check_output("pause_step", {3'b0, step}, 4'd0);
      check_output("pause_led", led, 4'b0001);
    end
    pause = 1'b0;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0011);
    mon_on = 1'b1;
    wait_drain(20);
    mon_on = 1'b0;

    // SCAN bounce.
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    apply_stimulus(2'd1);
    mon_on = 1'b1;
    tick();
    tick();
    check_output("scan_start", led, 4'b0001);
    wait_drain(60);
    mon_on = 1'b0;

    // FILL, then switch to SCAN mid-fill.
    exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001, 4'b0011};
    apply_stimulus(2'd2);
    mon_on = 1'b1;
    tick();
    tick();
    check_output("fill_start", led, 4'b0000);
    wait_drain(60);
    mon_on = 1'b0;
    mode = 2'd1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_output("switch_no_step", {3'b0, step}, 4'd0);
      check_output("switch_led", led, (k == 1) ? 4'b0011 : 4'b0001);
    end
    tick();
    check_output("switch_first_step", {3'b0, step}, 4'd1);

    // PWM brightness in STATIC.
    apply_stimulus(2'd3);
    tick();
    tick();
    bright = 2'd1;
    tick();
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (led == 4'b1111) ones++;
      else check_output("pwm_low", led, 4'b0000);
    end
    check_output("pwm_duty", 4'(ones), 4'd2);
    bright = 2'd0;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      check_output("bright_zero", led, 4'b0000);
    end
    check_output("bright_zero_al", led_al, 4'b0011);
    bright = 2'd3;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      check_output("bright_full", led, 4'b1111);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
